// File: rtl/conv_controller.sv
// Avalon-MM convolution accelerator: CPU-programmed registers, one master port that streams
// filters and input windows from SDRAM and writes Q8.24 output feature maps back.
module conv_controller #(
  parameter int CHANNELS   = 3,
  parameter int MAX_FWORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic        slave_waitrequest,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  output logic        master_write,
  output logic [31:0] master_writedata
);
  localparam int          BW = $clog2(MAX_FWORDS);
  localparam logic [31:0] CH = 32'(CHANNELS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOADF = 3'd1;
  localparam logic [2:0] S_ZERO  = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] in_base_q, in_base_d, flt_base_q, flt_base_d, out_base_q, out_base_d;
  logic [31:0] k_q, k_d, nf_q, nf_d, w_q, w_d;
  logic [31:0] f_q, f_d, oy_q, oy_d, ox_q, ox_d;
  logic [31:0] c_q, c_d, i_q, i_d, j_q, j_d, t_q, t_d;
  logic [63:0] acc_q, acc_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] fbuf_q [MAX_FWORDS];

  logic        busy_s, start_s, cfg_we_s, fbuf_we_s, unused_rd_s;
  logic [31:0] ckk_s, o_s, word_s;
  logic signed [63:0] mul_a_s, mul_b_s, prod_s;

  assign unused_rd_s       = slave_read;
  assign slave_waitrequest = 1'b0;
  assign busy_s   = (state_q != S_IDLE);
  assign start_s  = slave_write && (slave_address == 3'd0) && !busy_s;
  assign cfg_we_s = slave_write && !busy_s;
  assign ckk_s    = CH * k_q * k_q;
  assign o_s      = w_q - k_q + 32'd1;
  assign mul_a_s  = {{32{master_readdata[31]}}, master_readdata};
  assign mul_b_s  = {{32{fbuf_q[t_q[BW-1:0]][31]}}, fbuf_q[t_q[BW-1:0]]};
  assign prod_s   = mul_a_s * mul_b_s;

  assign master_address   = addr_q;
  assign master_read      = rd_q;
  assign master_write     = wr_q;
  assign master_writedata = wdata_q;

  // Register read mux
  always_comb begin
    case (slave_address)
      3'd0:    slave_readdata = {31'd0, done_q};
      3'd1:    slave_readdata = in_base_q;
      3'd2:    slave_readdata = flt_base_q;
      3'd3:    slave_readdata = out_base_q;
      3'd4:    slave_readdata = k_q;
      3'd5:    slave_readdata = nf_q;
      3'd6:    slave_readdata = w_q;
      default: slave_readdata = 32'd0;
    endcase
  end

  // Next-state logic: config writes, FSM sequencing and master request generation
  always_comb begin
    state_d = state_q;  done_d = done_q;
    in_base_d = in_base_q;  flt_base_d = flt_base_q;  out_base_d = out_base_q;
    k_d = k_q;  nf_d = nf_q;  w_d = w_q;
    f_d = f_q;  oy_d = oy_q;  ox_d = ox_q;
    c_d = c_q;  i_d = i_q;  j_d = j_q;  t_d = t_q;
    acc_d = acc_q;  fbuf_we_s = 1'b0;
    word_s = 32'd0;

    if (cfg_we_s) begin
      case (slave_address)
        3'd1:    in_base_d  = slave_writedata;
        3'd2:    flt_base_d = slave_writedata;
        3'd3:    out_base_d = slave_writedata;
        3'd4:    k_d        = slave_writedata;
        3'd5:    nf_d       = slave_writedata;
        3'd6:    w_d        = slave_writedata;
        default: in_base_d  = in_base_q;
      endcase
    end else begin
      in_base_d = in_base_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          done_d = 1'b0;
          f_d = 32'd0;  oy_d = 32'd0;  ox_d = 32'd0;
          c_d = 32'd0;  i_d = 32'd0;  j_d = 32'd0;  t_d = 32'd0;
          if ((nf_q == 32'd0) || (k_q == 32'd0) || (k_q > w_q)) state_d = S_DONE;
          else state_d = S_LOADF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOADF: begin
        if (rd_q && !master_waitrequest) begin
          fbuf_we_s = 1'b1;
          if (t_q == ckk_s - 32'd1) begin
            t_d = 32'd0;
            state_d = S_ZERO;
          end else begin
            t_d = t_q + 32'd1;
          end
        end else begin
          t_d = t_q;
        end
      end
      S_ZERO: begin
        acc_d = 64'd0;
        c_d = 32'd0;  i_d = 32'd0;  j_d = 32'd0;  t_d = 32'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (rd_q && !master_waitrequest) begin
          acc_d = acc_q + prod_s;
          t_d = t_q + 32'd1;
          // j fastest, then i, then channel: matches the filter buffer ordering
          if (j_q == k_q - 32'd1) begin
            j_d = 32'd0;
            if (i_q == k_q - 32'd1) begin
              i_d = 32'd0;
              if (c_q == CH - 32'd1) begin
                c_d = 32'd0;
                state_d = S_WRITE;
              end else begin
                c_d = c_q + 32'd1;
              end
            end else begin
              i_d = i_q + 32'd1;
            end
          end else begin
            j_d = j_q + 32'd1;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      S_WRITE: begin
        if (wr_q && !master_waitrequest) state_d = S_NEXT;
        else state_d = S_WRITE;
      end
      S_NEXT: begin
        if (ox_q == o_s - 32'd1) begin
          ox_d = 32'd0;
          if (oy_q == o_s - 32'd1) begin
            oy_d = 32'd0;
            if (f_q == nf_q - 32'd1) begin
              state_d = S_DONE;
            end else begin
              f_d = f_q + 32'd1;
              t_d = 32'd0;
              state_d = S_LOADF;
            end
          end else begin
            oy_d = oy_q + 32'd1;
            state_d = S_ZERO;
          end
        end else begin
          ox_d = ox_q + 32'd1;
          state_d = S_ZERO;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Requests derive from next-state counters, so they stay frozen while stalled
    rd_d = (state_d == S_LOADF) || (state_d == S_MAC);
    wr_d = (state_d == S_WRITE);
    case (state_d)
      S_LOADF: word_s = flt_base_q + f_d * ckk_s + t_d;
      S_MAC:   word_s = in_base_q + (c_d * w_q + oy_d + i_d) * w_q + ox_d + j_d;
      S_WRITE: word_s = out_base_q + f_d * o_s * o_s + oy_d * o_s + ox_d;
      default: word_s = addr_q >> 2;
    endcase
    addr_d  = {word_s[29:0], 2'b00};
    wdata_d = (state_d == S_WRITE) ? acc_d[55:24] : wdata_q;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  done_q <= 1'b0;
      in_base_q <= 32'd0;  flt_base_q <= 32'd0;  out_base_q <= 32'd0;
      k_q <= 32'd0;  nf_q <= 32'd0;  w_q <= 32'd0;
      f_q <= 32'd0;  oy_q <= 32'd0;  ox_q <= 32'd0;
      c_q <= 32'd0;  i_q <= 32'd0;  j_q <= 32'd0;  t_q <= 32'd0;
      acc_q <= 64'd0;
      rd_q <= 1'b0;  wr_q <= 1'b0;  addr_q <= 32'd0;  wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;  done_q <= done_d;
      in_base_q <= in_base_d;  flt_base_q <= flt_base_d;  out_base_q <= out_base_d;
      k_q <= k_d;  nf_q <= nf_d;  w_q <= w_d;
      f_q <= f_d;  oy_q <= oy_d;  ox_q <= ox_d;
      c_q <= c_d;  i_q <= i_d;  j_q <= j_d;  t_q <= t_d;
      acc_q <= acc_d;
      rd_q <= rd_d;  wr_q <= wr_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
    end
  end

  // Local filter buffer, filled during LOADF
  always_ff @(posedge clk) begin
    if (fbuf_we_s) fbuf_q[t_q[BW-1:0]] <= master_readdata;
  end
endmodule

// File: tb/tb_conv_controller.sv
// Scoreboard bench for conv_controller: SDRAM model with optional random stalls,
// expected output writes queued up front and checked by an independent monitor.
module tb_conv_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        slave_waitrequest;
  logic [2:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  conv_controller dut (
    .clk(clk), .reset(reset),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_write(master_write), .master_writedata(master_writedata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        stall_en = 1'b0;
  logic [31:0] mem [0:511];

  assign master_readdata = mem[master_address[10:2]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: hold-stability, strobe exclusivity, and scoreboard of accepted writes
  initial begin : monitor
    logic        prev_hold;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_rd, prev_wr;
    wr_t         e;
    prev_hold = 1'b0;
    prev_addr = 32'd0; prev_wdata = 32'd0; prev_rd = 1'b0; prev_wr = 1'b0;
    master_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_hold) begin
        check("hold_addr", {32'd0, master_address}, {32'd0, prev_addr});
        check("hold_strobes", {62'd0, master_read, master_write}, {62'd0, prev_rd, prev_wr});
        if (prev_wr) check("hold_wdata", {32'd0, master_writedata}, {32'd0, prev_wdata});
      end
      if (master_read || master_write)
        check("one_strobe", {63'd0, master_read & master_write}, 64'd0);
      master_waitrequest = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (master_write && !master_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {32'd0, master_address}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {32'd0, master_address}, {32'd0, e.addr});
          check("wr_data", {32'd0, master_writedata}, {32'd0, e.data});
        end
        mem[master_address[10:2]] = master_writedata;
      end
      prev_hold  = master_waitrequest && (master_read || master_write);
      prev_addr  = master_address;
      prev_wdata = master_writedata;
      prev_rd    = master_read;
      prev_wr    = master_write;
    end
  end

  task automatic init_mem(input bit neg);
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    for (int i = 1; i <= 108; i++) mem[i] = 32'h0100_0000;
    if (neg) begin
      for (int i = 128; i <= 154; i++) mem[i] = 32'hFFC0_0000;
    end else begin
      for (int i = 1; i <= 27; i++) mem[127 + i] = 32'(28 - i) * 32'h0040_0000;
      for (int i = 0; i <= 26; i++) mem[155 + i] = 32'(i) * 32'h0040_0000;
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_write = 1'b1; slave_address = a; slave_writedata = d;
    @(negedge clk);
    slave_write = 1'b0; slave_address = 3'd0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    #1 d = slave_readdata;
  endtask

  task automatic prog(input int inb, input int flt, input int outb, input int k, input int nf, input int w);
    wr_reg(3'd1, 32'(inb)); wr_reg(3'd2, 32'(flt)); wr_reg(3'd3, 32'(outb));
    wr_reg(3'd4, 32'(k));   wr_reg(3'd5, 32'(nf));  wr_reg(3'd6, 32'(w));
  endtask

  task automatic push_exp(input int outb, input int npix, input int f, input logic [31:0] v);
    wr_t e;
    for (int p = 0; p < npix; p++) begin
      e.addr = 32'((outb + f * npix + p) * 4);
      e.data = v;
      exp_q.push_back(e);
    end
  endtask

  // Poll done; optionally fire a START and a config write mid-run, both of which must be ignored
  task automatic wait_done(input string name, input int budget, input bit inject);
    bit seen;
    int cycles;
    seen = 1'b0; cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      slave_write = 1'b0; slave_address = 3'd0; slave_read = 1'b1;
      if (inject && cycles == 300) begin
        slave_write = 1'b1; slave_address = 3'd0; slave_writedata = 32'd0;
      end
      if (inject && cycles == 310) begin
        slave_write = 1'b1; slave_address = 3'd3; slave_writedata = 32'd400;
      end
      #1;
      if (slave_address == 3'd0 && slave_readdata[0]) seen = 1'b1;
      cycles++;
    end
    @(negedge clk);
    slave_write = 1'b0; slave_address = 3'd0;
    check(name, {63'd0, seen}, 64'd1);
    check({name, "_all_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    logic [31:0] d;
    int exp_regs[8] = '{0, 1, 128, 256, 3, 2, 6, 0};
    reset = 1'b1; slave_address = 3'd0; slave_read = 1'b0;
    slave_write = 1'b0; slave_writedata = 32'd0;
    init_mem(1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd_reg(3'd0, d); check("reg0_after_reset", {32'd0, d}, 64'd0);
    rd_reg(3'd3, d); check("reg3_after_reset", {32'd0, d}, 64'd0);
    check("waitrequest_tied", {63'd0, slave_waitrequest}, 64'd0);

    // Main run, with an ignored START and OUT_BASE write injected mid-run
    prog(1, 128, 256, 3, 2, 6);
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), d);
      check("reg_readback", {32'd0, d}, 64'(exp_regs[r]));
    end
    push_exp(256, 16, 0, 32'h5E80_0000);
    push_exp(256, 16, 1, 32'h57C0_0000);
    wr_reg(3'd0, 32'd0);
    wait_done("run1_done", 1400, 1'b1);
    rd_reg(3'd0, d); check("done_flag", {32'd0, d}, 64'd1);
    rd_reg(3'd3, d); check("out_base_unchanged", {32'd0, d}, 64'd256);
    check("mem256", {32'd0, mem[256]}, 64'h5E80_0000);
    check("mem287", {32'd0, mem[287]}, 64'h57C0_0000);

    // Same run under random stalls
    init_mem(1'b0);
    stall_en = 1'b1;
    push_exp(256, 16, 0, 32'h5E80_0000);
    push_exp(256, 16, 1, 32'h57C0_0000);
    wr_reg(3'd0, 32'd0);
    rd_reg(3'd0, d); check("start_clears_done", {32'd0, d}, 64'd0);
    wait_done("stall_done", 8000, 1'b0);
    stall_en = 1'b0;

    // Negative weights: 27 * -0.25 = -6.75
    init_mem(1'b1);
    prog(1, 128, 256, 3, 1, 6);
    push_exp(256, 16, 0, 32'hF940_0000);
    wr_reg(3'd0, 32'd0);
    wait_done("neg_done", 1400, 1'b0);

    // K == W: one output pixel
    init_mem(1'b0);
    prog(1, 128, 256, 3, 1, 3);
    push_exp(256, 1, 0, 32'h5E80_0000);
    wr_reg(3'd0, 32'd0);
    wait_done("kw_done", 200, 1'b0);

    // NF == 0 and K > W complete with no writes
    prog(1, 128, 256, 3, 0, 6);
    wr_reg(3'd0, 32'd0);
    wait_done("nf0_done", 10, 1'b0);
    prog(1, 128, 256, 4, 1, 3);
    wr_reg(3'd0, 32'd0);
    wait_done("kgtw_done", 10, 1'b0);

    // Reset mid-run (still loading filters, so no write is outstanding)
    prog(1, 128, 256, 3, 2, 6);
    wr_reg(3'd0, 32'd0);
    repeat (20) @(negedge clk);
    check("read_active_before_reset", {63'd0, master_read}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_read", {63'd0, master_read}, 64'd0);
    check("rst_write", {63'd0, master_write}, 64'd0);
    for (int r = 0; r < 8; r++) begin
      slave_address = 3'(r);
      #1 check("rst_reg", {32'd0, slave_readdata}, 64'd0);
    end
    reset = 1'b0;
    slave_address = 3'd0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("quiet_after_reset", {62'd0, master_read, master_write}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
